// File: rtl/ring_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ring_counter_ctrl
//  Brief    : Command sequencer for a bidirectional ring / Johnson counter.
//             Accepts LOAD / RUN_UP / RUN_DOWN over valid/ready, steps the
//             counter a commanded number of times, supports pause and abort.
//  Revision : 1.0  initial release
// ============================================================================
module ring_counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int JOHNSON = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] steps_left,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0]       OP_LOAD = 2'b00;
  localparam logic [1:0]       OP_UP   = 2'b01;
  localparam logic [1:0]       OP_DOWN = 2'b10;
  localparam logic [WIDTH-1:0] Q_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  // Ring mode must never hold all-zero; Johnson mode starts from all-zero.
  localparam logic [WIDTH-1:0] Q_RST   = (JOHNSON != 0) ? '0 : Q_ONE;
  localparam logic [CNT_W-1:0] STEP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] q_up;
  logic [WIDTH-1:0] q_dn;
  logic [WIDTH-1:0] load_val;
  logic [CNT_W-1:0] steps_nxt;
  logic             dir_up;
  logic             dir_up_nxt;
  logic             done_nxt;

  // Feedback bit differs between plain ring rotation and twisted-ring.
  generate
    if (JOHNSON != 0) begin : g_johnson
      assign q_up     = {q[WIDTH-2:0], ~q[WIDTH-1]};
      assign q_dn     = {~q[0], q[WIDTH-1:1]};
      assign load_val = cmd_data;
    end else begin : g_ring
      assign q_up     = {q[WIDTH-2:0], q[WIDTH-1]};
      assign q_dn     = {q[0], q[WIDTH-1:1]};
      // All-zero would be a dead state for a pure rotator; substitute 1.
      assign load_val = (cmd_data == '0) ? Q_ONE : cmd_data;
    end
  endgenerate

  assign busy      = (state == RUN);
  assign cmd_ready = (state == IDLE);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      q          <= Q_RST;
      steps_left <= '0;
      dir_up     <= 1'b1;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      q          <= q_nxt;
      steps_left <= steps_nxt;
      dir_up     <= dir_up_nxt;
      done       <= done_nxt;
    end
  end

  // Next-state, counter update and completion pulse.
  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    steps_nxt  = steps_left;
    dir_up_nxt = dir_up;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        // cmd_ready is high throughout IDLE, so valid alone means accept.
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              q_nxt    = load_val;
              done_nxt = 1'b1;
            end
            OP_UP, OP_DOWN: begin
              if (cmd_steps == '0) begin
                done_nxt = 1'b1;
              end else begin
                state_nxt  = RUN;
                steps_nxt  = cmd_steps;
                dir_up_nxt = (cmd_op == OP_UP);
              end
            end
            default: ;  // reserved opcode: consumed without effect
          endcase
        end
      end
      RUN: begin
        // abort takes priority over pause and suppresses done.
        if (abort) begin
          state_nxt = IDLE;
          steps_nxt = '0;
        end else if (!pause) begin
          q_nxt     = dir_up ? q_up : q_dn;
          steps_nxt = steps_left - STEP_ONE;
          if (steps_left == STEP_ONE) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_counter_ctrl
//  Brief    : Self-checking bench; ring and Johnson instances share stimulus
//             and are compared every cycle against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ring_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_steps;
  logic       pause;
  logic       abort;

  logic       ready_r, busy_r, done_r;
  logic [3:0] q_r;
  logic [7:0] sl_r;
  logic       ready_j, busy_j, done_j;
  logic [3:0] q_j;
  logic [7:0] sl_j;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ring_counter_ctrl #(.WIDTH(4), .CNT_W(8), .JOHNSON(0)) dut_r (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_r),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps),
    .pause(pause), .abort(abort), .q(q_r), .steps_left(sl_r),
    .busy(busy_r), .done(done_r)
  );

  ring_counter_ctrl #(.WIDTH(4), .CNT_W(8), .JOHNSON(1)) dut_j (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_j),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps),
    .pause(pause), .abort(abort), .q(q_j), .steps_left(sl_j),
    .busy(busy_j), .done(done_j)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0 = ring, 1 = Johnson) -------
  int m_q    [2];
  int m_sl   [2];
  bit m_busy [2];
  bit m_up   [2];
  bit m_done [2];
  bit m_started = 1'b0;

  function automatic int step4(input int v, input bit up, input bit twisted);
    int b;
    if (up) begin
      b = (v >> 3) & 1;
      if (twisted) b = b ^ 1;
      return ((v << 1) & 15) | b;
    end else begin
      b = v & 1;
      if (twisted) b = b ^ 1;
      return (v >> 1) | (b << 3);
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_q[i] = (i == 1) ? 0 : 1;
        m_sl[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_up[i] = 1'b1;
      end else begin
        m_done[i] = 1'b0;
        if (!m_busy[i]) begin
          if (cmd_valid) begin
            if (cmd_op == 2'd0) begin
              m_q[i] = (i == 0 && cmd_data == 4'd0) ? 1 : int'(cmd_data);
              m_done[i] = 1'b1;
            end else if (cmd_op == 2'd1 || cmd_op == 2'd2) begin
              if (cmd_steps == 8'd0) m_done[i] = 1'b1;
              else begin
                m_busy[i] = 1'b1; m_sl[i] = int'(cmd_steps); m_up[i] = (cmd_op == 2'd1);
              end
            end
          end
        end else if (abort) begin
          m_busy[i] = 1'b0; m_sl[i] = 0;
        end else if (!pause) begin
          m_q[i] = step4(m_q[i], m_up[i], i == 1);
          m_sl[i] = m_sl[i] - 1;
          if (m_sl[i] == 0) begin m_busy[i] = 1'b0; m_done[i] = 1'b1; end
        end
      end
    end
    if (rst) m_started = 1'b1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_started) begin
      chk("model_q_ring",     32'(q_r),     32'(m_q[0]));
      chk("model_sl_ring",    32'(sl_r),    32'(m_sl[0]));
      chk("model_busy_ring",  32'(busy_r),  32'(m_busy[0]));
      chk("model_ready_ring", 32'(ready_r), 32'(!m_busy[0]));
      chk("model_done_ring",  32'(done_r),  32'(m_done[0]));
      chk("model_q_john",     32'(q_j),     32'(m_q[1]));
      chk("model_sl_john",    32'(sl_j),    32'(m_sl[1]));
      chk("model_busy_john",  32'(busy_j),  32'(m_busy[1]));
      chk("model_ready_john", 32'(ready_j), 32'(!m_busy[1]));
      chk("model_done_john",  32'(done_j),  32'(m_done[1]));
    end
  end

  // ---------------- directed stimulus with literal expectations ----------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_steps = steps;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [3:0] john_seq [8];

  initial begin
    john_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 4'd0; cmd_steps = 8'd0;
    pause = 1'b0; abort = 1'b0;

    // Reset state
    tick(); tick(); rst = 1'b0;
    chk("rst_q_ring", 32'(q_r), 32'h1);
    chk("rst_q_john", 32'(q_j), 32'h0);
    chk("rst_busy", 32'(busy_r), 32'h0);
    chk("rst_ready", 32'(ready_r), 32'h1);
    chk("rst_done", 32'(done_r), 32'h0);

    // LOAD 0100 then RUN_UP 3
    send(2'b00, 4'b0100, 8'd0);
    chk("load_q", 32'(q_r), 32'h4);
    chk("load_done", 32'(done_r), 32'h1);
    send(2'b01, 4'd0, 8'd3);
    chk("up_accept_busy", 32'(busy_r), 32'h1);
    chk("up_accept_sl", 32'(sl_r), 32'd3);
    tick(); chk("up_e1_q", 32'(q_r), 32'h8); chk("up_e1_sl", 32'(sl_r), 32'd2);
    tick(); chk("up_e2_q", 32'(q_r), 32'h1); chk("up_e2_sl", 32'(sl_r), 32'd1);
    tick(); chk("up_e3_q", 32'(q_r), 32'h2); chk("up_e3_sl", 32'(sl_r), 32'd0);
    chk("up_e3_done", 32'(done_r), 32'h1);
    tick(); chk("up_done_pulse", 32'(done_r), 32'h0);

    // LOAD 0000 in ring mode, then RUN_DOWN 2
    send(2'b00, 4'b0000, 8'd0);
    chk("load0_ring", 32'(q_r), 32'h1);
    chk("load0_john", 32'(q_j), 32'h0);
    send(2'b10, 4'd0, 8'd2);
    tick(); chk("dn_e1_q", 32'(q_r), 32'h8);
    tick(); chk("dn_e2_q", 32'(q_r), 32'h4); chk("dn_done", 32'(done_r), 32'h1);

    // RUN_UP 4 with two-cycle pause and a command held during RUN
    send(2'b01, 4'd0, 8'd4);
    tick(); chk("pz_e1_q", 32'(q_r), 32'h8);
    pause = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b1111;
    tick(); chk("pz_hold1_q", 32'(q_r), 32'h8); chk("pz_hold1_sl", 32'(sl_r), 32'd3);
    chk("pz_ready", 32'(ready_r), 32'h0);
    tick(); chk("pz_hold2_q", 32'(q_r), 32'h8); chk("pz_hold2_sl", 32'(sl_r), 32'd3);
    pause = 1'b0; cmd_valid = 1'b0;
    tick(); chk("pz_e2_q", 32'(q_r), 32'h1);
    tick(); chk("pz_e3_done", 32'(done_r), 32'h0);
    tick(); chk("pz_e4_q", 32'(q_r), 32'h4); chk("pz_e4_done", 32'(done_r), 32'h1);

    // RUN_UP 10 aborted (with pause) after 3 steps, then idle abort, NOP, S=0
    send(2'b01, 4'd0, 8'd10);
    tick(); tick(); tick();
    chk("ab_pre_q", 32'(q_r), 32'h2); chk("ab_pre_sl", 32'(sl_r), 32'd7);
    abort = 1'b1; pause = 1'b1;
    tick();
    chk("ab_busy", 32'(busy_r), 32'h0); chk("ab_q", 32'(q_r), 32'h2);
    chk("ab_sl", 32'(sl_r), 32'd0); chk("ab_done", 32'(done_r), 32'h0);
    abort = 1'b0; pause = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_idle_q", 32'(q_r), 32'h2);
    send(2'b11, 4'b1111, 8'd5);
    chk("nop_done", 32'(done_r), 32'h0); chk("nop_q", 32'(q_r), 32'h2);
    chk("nop_busy", 32'(busy_r), 32'h0);
    send(2'b01, 4'd0, 8'd0);
    chk("s0_done", 32'(done_r), 32'h1); chk("s0_q", 32'(q_r), 32'h2);
    chk("s0_busy", 32'(busy_r), 32'h0);

    // Johnson sequence from 0000, then reset mid-RUN
    rst = 1'b1; tick(); rst = 1'b0;
    chk("j_rst_q", 32'(q_j), 32'h0);
    send(2'b01, 4'd0, 8'd8);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("j_seq%0d", k), 32'(q_j), 32'(john_seq[k]));
    end
    chk("j_done", 32'(done_j), 32'h1);
    send(2'b01, 4'd0, 8'd8);
    tick(); tick(); tick();
    chk("j_mid_q", 32'(q_j), 32'h7);
    rst = 1'b1;
    tick();
    chk("j_rst_mid_q", 32'(q_j), 32'h0); chk("j_rst_mid_busy", 32'(busy_j), 32'h0);
    chk("j_rst_mid_done", 32'(done_j), 32'h0); chk("r_rst_mid_q", 32'(q_r), 32'h1);
    chk("j_rst_mid_sl", 32'(sl_j), 32'd0);
    rst = 1'b0;
    tick(); chk("j_post_rst_done", 32'(done_j), 32'h0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
